// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered 2:1 mux level per shift-amount bit,
// supporting SLL/SRL/SRA/ROR behind a valid/ready stream with a global stall.
module barrel_shifter_pipe #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    logic w_advance;

    // The whole pipe moves together; an unaccepted result freezes every stage.
    assign w_advance = !out_valid | out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;

        logic                     w_vld;
        logic [WIDTH-1:0]         w_d;
        logic signed [WIDTH-1:0]  w_ds;
        logic [SHW-1:0]           w_sh;
        logic [1:0]               w_md;
        logic [WIDTH-1:0]         w_res;

        logic                     r_vld;
        logic [WIDTH-1:0]         r_data;
        logic [SHW-1:0]           r_sh;
        logic [1:0]               r_md;

        if (k == 0) begin : g_head
            assign w_vld = in_valid & w_advance;
            assign w_d   = in_data;
            assign w_sh  = in_shamt;
            assign w_md  = in_mode;
        end else begin : g_body
            assign w_vld = g_stage[k-1].r_vld;
            assign w_d   = g_stage[k-1].r_data;
            assign w_sh  = g_stage[k-1].r_sh;
            assign w_md  = g_stage[k-1].r_md;
        end

        assign w_ds = w_d;

        always_comb begin
            w_res = w_d;
            if (w_sh[k]) begin
                unique case (w_md)
                    MODE_SLL: w_res = {w_d[WIDTH-1-S:0], {S{1'b0}}};
                    MODE_SRL: w_res = {{S{1'b0}}, w_d[WIDTH-1:S]};
                    MODE_SRA: w_res = w_ds >>> S;
                    MODE_ROR: w_res = {w_d[S-1:0], w_d[WIDTH-1:S]};
                    default:  w_res = w_d;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_sh   <= '0;
                r_md   <= '0;
            end else if (w_advance) begin
                r_vld  <= w_vld;
                r_data <= w_res;
                r_sh   <= w_sh;
                r_md   <= w_md;
            end
        end
    end

    assign out_valid = g_stage[SHW-1].r_vld;
    assign out_data  = g_stage[SHW-1].r_data;
endmodule
